// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: UI/mode scheduler for the alarm clock.
// Routes the debounced buttons to the time setter, the alarm setter or the
// ringer, and sequences RUN / SET_TIME / SET_ALARM / RING / SNOOZE.
// Ports:
//   clk_100MHz, rst_n (sync, active-low), tick_1hz (1-cycle pulse)
//   set_btn, right_btn, left_btn, inc_btn, dec_btn (1-cycle pulses)
//   alarm_match, alarm_off_sw (levels)
//   mode[2:0], digit_sel[1:0], count_en, time_inc, time_dec,
//   alarm_inc, alarm_dec, ring_led (all registered)
module clock_mode_ctrl #(
    parameter int IDLE_TIMEOUT_S = 10,
    parameter int RING_S         = 60,
    parameter int SNOOZE_S       = 30
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       set_btn,
    input  logic       right_btn,
    input  logic       left_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic       alarm_match,
    input  logic       alarm_off_sw,
    output logic [2:0] mode,
    output logic [1:0] digit_sel,
    output logic       count_en,
    output logic       time_inc,
    output logic       time_dec,
    output logic       alarm_inc,
    output logic       alarm_dec,
    output logic       ring_led
);

    localparam int MAX_A = (IDLE_TIMEOUT_S > RING_S) ? IDLE_TIMEOUT_S : RING_S;
    localparam int MAX_P = (MAX_A > SNOOZE_S) ? MAX_A : SNOOZE_S;
    localparam int TW    = $clog2(MAX_P + 1);

    localparam logic [TW-1:0] IDLE_LIM   = TW'(IDLE_TIMEOUT_S);
    localparam logic [TW-1:0] RING_LIM   = TW'(RING_S);
    localparam logic [TW-1:0] SNOOZE_LIM = TW'(SNOOZE_S);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_TIME  = 3'd1,
        SET_ALARM = 3'd2,
        RING      = 3'd3,
        SNOOZE    = 3'd4
    } state_t;

    state_t        state, state_d;
    logic [1:0]    digit_d;
    logic [TW-1:0] idle_t, idle_d, idle_nx;
    // Shared by RING and SNOOZE; cleared whenever either is entered.
    logic [TW-1:0] alrm_t, alrm_d, alrm_nx;
    logic          match_q;

    logic time_inc_d, time_dec_d, alarm_inc_d, alarm_dec_d;
    logic count_en_d, ring_led_d;

    // One-hot priority resolution: set > right > left > inc > dec.
    logic p_set, p_right, p_left, p_inc, p_dec, btn_any, match_rise;

    always_comb begin
        p_set      = set_btn;
        p_right    = right_btn & ~set_btn;
        p_left     = left_btn & ~set_btn & ~right_btn;
        p_inc      = inc_btn & ~set_btn & ~right_btn & ~left_btn;
        p_dec      = dec_btn & ~set_btn & ~right_btn & ~left_btn & ~inc_btn;
        btn_any    = p_set | p_right | p_left | p_inc | p_dec;
        match_rise = alarm_match & ~match_q;
        idle_nx    = (&idle_t) ? idle_t : idle_t + 1'b1;
        alrm_nx    = (&alrm_t) ? alrm_t : alrm_t + 1'b1;
    end

    // State register (outputs are registered alongside).
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            state     <= RUN;
            digit_sel <= 2'd0;
            idle_t    <= '0;
            alrm_t    <= '0;
            match_q   <= 1'b0;
            count_en  <= 1'b1;
            time_inc  <= 1'b0;
            time_dec  <= 1'b0;
            alarm_inc <= 1'b0;
            alarm_dec <= 1'b0;
            ring_led  <= 1'b0;
        end else begin
            state     <= state_d;
            digit_sel <= digit_d;
            idle_t    <= idle_d;
            alrm_t    <= alrm_d;
            match_q   <= alarm_match;
            count_en  <= count_en_d;
            time_inc  <= time_inc_d;
            time_dec  <= time_dec_d;
            alarm_inc <= alarm_inc_d;
            alarm_dec <= alarm_dec_d;
            ring_led  <= ring_led_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        digit_d = digit_sel;
        idle_d  = '0;
        alrm_d  = '0;
        case (state)
            RUN: begin
                if (match_rise && !alarm_off_sw) begin
                    state_d = RING;
                end else if (p_set) begin
                    state_d = SET_TIME;
                    digit_d = 2'd0;
                end
            end
            SET_TIME, SET_ALARM: begin
                if (p_set) begin
                    state_d = (state == SET_TIME) ? SET_ALARM : RUN;
                    if (state == SET_TIME) digit_d = 2'd0;
                end else if (btn_any) begin
                    if (p_right) digit_d = digit_sel + 2'd1;
                    if (p_left)  digit_d = digit_sel - 2'd1;
                end else if (tick_1hz) begin
                    if (idle_nx >= IDLE_LIM) state_d = RUN;
                    else idle_d = idle_nx;
                end else begin
                    idle_d = idle_t;
                end
            end
            RING: begin
                if (alarm_off_sw) begin
                    state_d = RUN;
                end else if (p_right | p_left | p_inc | p_dec) begin
                    state_d = SNOOZE;
                end else if (tick_1hz) begin
                    if (alrm_nx >= RING_LIM) state_d = RUN;
                    else alrm_d = alrm_nx;
                end else begin
                    alrm_d = alrm_t;
                end
            end
            SNOOZE: begin
                if (alarm_off_sw) begin
                    state_d = RUN;
                end else if (tick_1hz) begin
                    if (alrm_nx >= SNOOZE_LIM) state_d = RING;
                    else alrm_d = alrm_nx;
                end else begin
                    alrm_d = alrm_t;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Output logic (next values of the registered outputs).
    always_comb begin
        time_inc_d  = (state == SET_TIME) & p_inc;
        time_dec_d  = (state == SET_TIME) & p_dec;
        alarm_inc_d = (state == SET_ALARM) & p_inc;
        alarm_dec_d = (state == SET_ALARM) & p_dec;
        count_en_d  = (state_d != SET_TIME);
        ring_led_d  = (state_d == RING);
    end

    assign mode = state;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Testbench for clock_mode_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_clock_mode_ctrl;

    logic       clk_100MHz = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       set_btn = 1'b0, right_btn = 1'b0, left_btn = 1'b0;
    logic       inc_btn = 1'b0, dec_btn = 1'b0;
    logic       alarm_match = 1'b0, alarm_off_sw = 1'b0;
    logic [2:0] mode;
    logic [1:0] digit_sel;
    logic       count_en, time_inc, time_dec, alarm_inc, alarm_dec, ring_led;

    int n_checks = 0;
    int n_fail = 0;

    clock_mode_ctrl dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .set_btn     (set_btn),
        .right_btn   (right_btn),
        .left_btn    (left_btn),
        .inc_btn     (inc_btn),
        .dec_btn     (dec_btn),
        .alarm_match (alarm_match),
        .alarm_off_sw(alarm_off_sw),
        .mode        (mode),
        .digit_sel   (digit_sel),
        .count_en    (count_en),
        .time_inc    (time_inc),
        .time_dec    (time_dec),
        .alarm_inc   (alarm_inc),
        .alarm_dec   (alarm_dec),
        .ring_led    (ring_led)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Behavioural model: elapsed seconds in the current SET_*/RING/SNOOZE.
    int m_mode, m_dig, m_idle, m_secs;
    bit m_amq, m_tinc, m_tdec, m_ainc, m_adec;

    localparam logic [4:0] B_SET = 5'b10000, B_RIGHT = 5'b01000;
    localparam logic [4:0] B_LEFT = 5'b00100, B_INC = 5'b00010;
    localparam logic [4:0] B_DEC = 5'b00001, B_NONE = 5'b00000;

    task automatic model(input logic [4:0] b, input logic tk);
        int w;
        bit rise;
        if (!rst_n) begin
            m_mode = 0; m_dig = 0; m_idle = 0; m_secs = 0; m_amq = 0;
            m_tinc = 0; m_tdec = 0; m_ainc = 0; m_adec = 0;
            return;
        end
        rise = alarm_match && !m_amq;
        m_amq = alarm_match;
        m_tinc = 0; m_tdec = 0; m_ainc = 0; m_adec = 0;
        w = 0;
        for (int k = 5; k >= 1; k--) if (w == 0 && b[k-1]) w = 6 - k;
        case (m_mode)
            0: begin
                if (rise && !alarm_off_sw) begin
                    m_mode = 3; m_secs = 0;
                end else if (w == 1) begin
                    m_mode = 1; m_dig = 0; m_idle = 0;
                end
            end
            1, 2: begin
                if (w != 0) m_idle = 0;
                if (w == 1) begin
                    if (m_mode == 1) m_dig = 0;
                    m_mode = (m_mode == 1) ? 2 : 0;
                end else if (w == 2) m_dig = (m_dig + 1) % 4;
                else if (w == 3) m_dig = (m_dig + 3) % 4;
                else if (w == 4) begin
                    if (m_mode == 1) m_tinc = 1; else m_ainc = 1;
                end else if (w == 5) begin
                    if (m_mode == 1) m_tdec = 1; else m_adec = 1;
                end else if (tk) begin
                    m_idle++;
                    if (m_idle == 10) m_mode = 0;
                end
            end
            3: begin
                if (alarm_off_sw) m_mode = 0;
                else if (w >= 2) begin
                    m_mode = 4; m_secs = 0;
                end else if (tk) begin
                    m_secs++;
                    if (m_secs == 60) m_mode = 0;
                end
            end
            default: begin
                if (alarm_off_sw) m_mode = 0;
                else if (tk) begin
                    m_secs++;
                    if (m_secs == 30) begin
                        m_mode = 3; m_secs = 0;
                    end
                end
            end
        endcase
    endtask

    function automatic logic [9:0] dut_vec();
        return {mode, digit_sel, count_en, time_inc, time_dec,
                alarm_inc, alarm_dec, ring_led};
    endfunction

    function automatic logic [9:0] exp_vec();
        return {3'(m_mode), 2'(m_dig), m_mode != 1, m_tinc, m_tdec,
                m_ainc, m_adec, m_mode == 3};
    endfunction

    task automatic step(input logic [4:0] b, input logic tk);
        @(negedge clk_100MHz);
        {set_btn, right_btn, left_btn, inc_btn, dec_btn} = b;
        tick_1hz = tk;
        @(posedge clk_100MHz);
        model(b, tk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(B_NONE, 1'b0);
        step(B_NONE, 1'b0);
        n_checks++;
        if (dut_vec() !== 10'b000_00_1_0000_0) begin
            n_fail++;
            $display("FAIL reset: got %b want %b", dut_vec(), 10'b000_00_1_0000_0);
        end
        rst_n = 1'b1;
        step(B_NONE, 1'b0);
    endtask

    task automatic test_digit_wrap();
        step(B_SET, 1'b0);
        for (int i = 0; i < 5; i++) step(B_RIGHT, 1'b0);
        n_checks++;
        if ({mode, count_en, digit_sel} !== {3'd1, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL digit_wrap: mode=%0d cen=%b dig=%0d want 1 0 1",
                     mode, count_en, digit_sel);
        end
        step(B_LEFT, 1'b0);
        step(B_LEFT, 1'b0);
        n_checks++;
        if (digit_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL digit_left_wrap: got %0d want 3", digit_sel);
        end
        step(B_RIGHT, 1'b0);
        step(B_RIGHT, 1'b0);
    endtask

    task automatic test_time_incdec();
        int ti, td, ai, ad;
        logic [4:0] seq [4] = '{B_INC, B_INC, B_INC, B_DEC};
        ti = 0; td = 0; ai = 0; ad = 0;
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1'b0);
            ti += int'(time_inc); td += int'(time_dec);
            ai += int'(alarm_inc); ad += int'(alarm_dec);
            step(B_NONE, 1'b0);
            ti += int'(time_inc); td += int'(time_dec);
            ai += int'(alarm_inc); ad += int'(alarm_dec);
            step(B_NONE, 1'b0);
        end
        n_checks++;
        if ({ti, td, ai, ad} !== {32'd3, 32'd1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL time_incdec: ti=%0d td=%0d ai=%0d ad=%0d want 3 1 0 0",
                     ti, td, ai, ad);
        end
    endtask

    task automatic test_idle_timeout();
        step(B_SET, 1'b0);
        n_checks++;
        if (mode !== 3'd2 || digit_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL enter_set_alarm: mode=%0d dig=%0d want 2 0", mode, digit_sel);
        end
        step(B_INC, 1'b1);
        n_checks++;
        if ({alarm_inc, time_inc} !== 2'b10) begin
            n_fail++;
            $display("FAIL alarm_inc: got %b want 10", {alarm_inc, time_inc});
        end
        for (int k = 1; k <= 10; k++) begin
            step(B_NONE, 1'b1);
            if (k >= 9) begin
                n_checks++;
                if (mode !== ((k == 10) ? 3'd0 : 3'd2)) begin
                    n_fail++;
                    $display("FAIL idle_timeout tick%0d: mode=%0d want %0d",
                             k, mode, (k == 10) ? 0 : 2);
                end
            end
            step(B_NONE, 1'b0);
        end
    endtask

    task automatic test_ring_snooze();
        alarm_match = 1'b1;
        step(B_SET, 1'b0);
        n_checks++;
        if ({mode, ring_led} !== {3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL ring_over_set: mode=%0d led=%b want 3 1", mode, ring_led);
        end
        step(B_INC, 1'b0);
        n_checks++;
        if ({mode, ring_led, time_inc, alarm_inc} !== {3'd4, 3'b000}) begin
            n_fail++;
            $display("FAIL snooze: mode=%0d led=%b want 4 0", mode, ring_led);
        end
        for (int k = 1; k <= 30; k++) begin
            step(B_NONE, 1'b1);
            if (k >= 29) begin
                n_checks++;
                if (mode !== ((k == 30) ? 3'd3 : 3'd4)) begin
                    n_fail++;
                    $display("FAIL snooze_timeout tick%0d: mode=%0d", k, mode);
                end
            end
        end
    endtask

    task automatic test_ring_timeout();
        for (int k = 1; k <= 60; k++) begin
            step(B_NONE, 1'b1);
            if (k >= 59) begin
                n_checks++;
                if ({mode, ring_led} !== ((k == 60) ? 4'b0000 : 4'b0111)) begin
                    n_fail++;
                    $display("FAIL ring_timeout tick%0d: mode=%0d led=%b", k, mode, ring_led);
                end
            end
        end
        for (int i = 0; i < 5; i++) step(B_NONE, 1'b1);
        n_checks++;
        if (mode !== 3'd0) begin
            n_fail++;
            $display("FAIL no_rering: mode=%0d want 0", mode);
        end
    endtask

    task automatic test_off_priority();
        alarm_match = 1'b0;
        step(B_NONE, 1'b0);
        alarm_match = 1'b1;
        step(B_NONE, 1'b0);
        n_checks++;
        if (mode !== 3'd3) begin
            n_fail++;
            $display("FAIL ring_again: mode=%0d want 3", mode);
        end
        alarm_off_sw = 1'b1;
        step(B_INC, 1'b0);
        n_checks++;
        if ({mode, ring_led} !== 4'b0000) begin
            n_fail++;
            $display("FAIL off_over_inc: mode=%0d led=%b want 0 0", mode, ring_led);
        end
        alarm_off_sw = 1'b0;
        alarm_match = 1'b0;
        step(B_NONE, 1'b0);
    endtask

    task automatic test_reset_snooze();
        alarm_match = 1'b1;
        step(B_NONE, 1'b0);
        step(B_LEFT, 1'b0);
        for (int i = 0; i < 5; i++) step(B_NONE, 1'b1);
        n_checks++;
        if (mode !== 3'd4) begin
            n_fail++;
            $display("FAIL pre_reset_snooze: mode=%0d want 4", mode);
        end
        alarm_match = 1'b0;
        rst_n = 1'b0;
        step(B_NONE, 1'b1);
        n_checks++;
        if (dut_vec() !== 10'b000_00_1_0000_0) begin
            n_fail++;
            $display("FAIL reset_in_snooze: got %b want %b", dut_vec(), 10'b000_00_1_0000_0);
        end
        rst_n = 1'b1;
        step(B_NONE, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] b;
        logic tk;
        for (int c = 0; c < 4000; c++) begin
            b = B_NONE;
            for (int k = 0; k < 5; k++) if ($urandom_range(0, 99) == 0) b[k] = 1'b1;
            tk = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) alarm_match = ~alarm_match;
            alarm_off_sw = ($urandom_range(0, 299) == 0);
            rst_n = ($urandom_range(0, 1999) != 0);
            step(b, tk);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
            end
        end
        rst_n = 1'b1;
        alarm_off_sw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_digit_wrap();
        test_time_incdec();
        test_idle_timeout();
        test_ring_snooze();
        test_ring_timeout();
        test_off_priority();
        test_reset_snooze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
